// File: rtl/quadrature_decoder.sv
// Quadrature encoder decoder: synchronizes A/B, decodes Gray-code phase steps
// into an up/down position counter with a sticky illegal-transition flag.
module quadrature_decoder #(
    parameter int WIDTH = 12
) (
    input  logic             clk_in,
    input  logic             rst_n_in,
    input  logic             a_in,
    input  logic             b_in,
    input  logic             sync_load_in,
    input  logic [WIDTH-1:0] count_in,
    input  logic             err_clr_in,
    output logic [WIDTH-1:0] count_out,
    output logic             updown_out,
    output logic             step_out,
    output logic             err_out
);

    localparam logic [WIDTH-1:0] ONE = {{(WIDTH-1){1'b0}}, 1'b1};

    logic [1:0]       r_sync1;
    logic [1:0]       r_sync2;
    logic [1:0]       r_prev;
    logic [1:0]       r_warm;
    logic [WIDTH-1:0] r_count;
    logic             r_updown;
    logic             r_step;
    logic             r_err;

    logic [1:0] w_pos_cur;
    logic [1:0] w_pos_prev;
    logic [1:0] w_delta;
    logic       w_active;
    logic       w_up;
    logic       w_down;
    logic       w_illegal;

    // Map Gray phase {A,B} to linear position 0..3 so a step is a +/-1 difference.
    assign w_pos_cur  = {r_sync2[1], r_sync2[1] ^ r_sync2[0]};
    assign w_pos_prev = {r_prev[1], r_prev[1] ^ r_prev[0]};
    assign w_delta    = w_pos_cur - w_pos_prev;
    assign w_active   = (r_warm == 2'd3);
    assign w_up       = w_active && (w_delta == 2'd1);
    assign w_down     = w_active && (w_delta == 2'd3);
    assign w_illegal  = w_active && (w_delta == 2'd2);

    always_ff @(posedge clk_in or negedge rst_n_in) begin
        if (!rst_n_in) begin
            r_sync1  <= 2'b00;
            r_sync2  <= 2'b00;
            r_prev   <= 2'b00;
            r_warm   <= 2'd0;
            r_count  <= '0;
            r_updown <= 1'b0;
            r_step   <= 1'b0;
            r_err    <= 1'b0;
        end else begin
            r_sync1 <= {a_in, b_in};
            r_sync2 <= r_sync1;
            r_prev  <= r_sync2;
            // Warm-up lets prev catch up with a resting encoder before decoding.
            if (!w_active) begin
                r_warm <= r_warm + 2'd1;
            end
            r_step <= w_up | w_down;
            if (w_up | w_down) begin
                r_updown <= w_up;
            end
            if (sync_load_in) begin
                r_count <= count_in;
            end else if (w_up) begin
                r_count <= r_count + ONE;
            end else if (w_down) begin
                r_count <= r_count - ONE;
            end
            if (w_illegal) begin
                r_err <= 1'b1;
            end else if (err_clr_in) begin
                r_err <= 1'b0;
            end
        end
    end

    assign count_out  = r_count;
    assign updown_out = r_updown;
    assign step_out   = r_step;
    assign err_out    = r_err;

endmodule
